scan_sequencer: RTL

- Parametrised successor to the fixed 8:1-mux polling controller.
- Steps a mux address across NUM_CH sensor channels and waits a settle time after each switch.
- Discards the in-flight ADC conversion, then averages 2^AVG_LOG2 ADC samples and pushes one byte per channel into an internal FIFO. Each frame is preceded by a sync byte.
- Supports single-frame and continuous modes. The FIFO read side feeds the UART transmitter.

---
 rtl/scan_pkg.sv | 19 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/scan_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state encoding, default frame sync byte and clog2 helper for scan_sequencer
package scan_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_SETTLE  = 3'd2,
    S_DISCARD = 3'd3,
    S_ACCUM   = 3'd4,
    S_PUSH    = 3'd5,
    S_NEXT    = 3'd6
  } state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-read FIFO dropping writes when full; ports clk, reset_n, wr_en, wr_data, rd_en, rd_data, empty, full
module sync_fifo
  import scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic do_wr, do_rd;
  always_comb begin
    do_wr = wr_en && !full;
    do_rd = rd_en && !empty;
    count_n = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_n;
      empty <= count_n == '0;
      full <= count_n == (AW+1)'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: mux-scanning ADC averager pushing sync-headed frames into a FIFO; ports clk, reset_n, start_n, mode, adc_valid, adc_data, addr, rd_en, rd_data, empty, full, busy, frame_done, overflow
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int NUM_CH = 48,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 12,
  parameter int OUT_W = 8,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE_CYC = 500,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int FIFO_DEPTH = 64,
  parameter logic [OUT_W-1:0] SYNC_BYTE = OUT_W'(SYNC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_n,
  input  logic              mode,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [OUT_W-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int CW = clog2(SETTLE_CYC + (1 << AVG_LOG2)) + 1;
  localparam int DW = clog2(DEBOUNCE_CYC) + 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] acc, acc_n;
  logic mode_q, mode_n, stop_q, stop_n, ovf_n, done_n, push;
  logic [OUT_W-1:0] push_data;
  logic s1, s2, deb, deb_p, start_req;
  logic [DW-1:0] dcnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      deb <= 1'b1;
      deb_p <= 1'b1;
      dcnt <= '0;
    end else begin
      s1 <= start_n;
      s2 <= s1;
      deb_p <= deb;
      if (s2 == deb) dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
        deb <= s2;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  end
  assign start_req = deb_p && !deb;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    addr_n = addr;
    cnt_n = cnt;
    acc_n = acc;
    mode_n = mode_q;
    stop_n = stop_q || (start_req && busy && mode_q);
    done_n = 1'b0;
    push = state == S_HDR || state == S_PUSH;
    push_data = (state == S_HDR) ? SYNC_BYTE : OUT_W'(acc >> (AVG_LOG2 + DATA_W - OUT_W));
    ovf_n = overflow || (push && full);
    case (state)
      S_IDLE: if (start_req) begin
        state_n = S_HDR;
        mode_n = mode;
        stop_n = 1'b0;
        ovf_n = 1'b0;
        addr_n = '0;
      end
      S_HDR: state_n = S_SETTLE;
      S_SETTLE: begin
        cnt_n = (cnt == CW'(SETTLE_CYC - 1)) ? '0 : cnt + 1'b1;
        state_n = (cnt == CW'(SETTLE_CYC - 1)) ? S_DISCARD : S_SETTLE;
      end
      S_DISCARD: state_n = adc_valid ? S_ACCUM : S_DISCARD;
      S_ACCUM: if (adc_valid) begin
        acc_n = acc + AW'(adc_data);
        cnt_n = (cnt == CW'((1 << AVG_LOG2) - 1)) ? '0 : cnt + 1'b1;
        state_n = (cnt == CW'((1 << AVG_LOG2) - 1)) ? S_PUSH : S_ACCUM;
      end
      S_PUSH: begin
        acc_n = '0;
        state_n = S_NEXT;
      end
      S_NEXT: if (addr < ADDR_W'(NUM_CH - 1)) begin
        addr_n = addr + 1'b1;
        state_n = S_SETTLE;
      end else begin
        done_n = 1'b1;
        addr_n = '0;
        state_n = (!mode_q || stop_q) ? S_IDLE : S_HDR;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      addr <= '0;
      cnt <= '0;
      acc <= '0;
      mode_q <= 1'b0;
      stop_q <= 1'b0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      cnt <= cnt_n;
      acc <= acc_n;
      mode_q <= mode_n;
      stop_q <= stop_n;
      overflow <= ovf_n;
      frame_done <= done_n;
    end
  end
  sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(push),
    .wr_data(push_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full)
  );
endmodule
